phy_rx_lane_align: RTL
======================

Name: phy_rx_lane_align

Overview:
- Per-lane serial-to-parallel converter with comma-based byte alignment. It sits at the front of each PHY receive lane, directly upstream of the lane byte-unstriping and 32-bit reassembly logic.
- Input: one serial bit per clock, MSB first, as driven by the transmit-side parallel-to-serial stage.
- Hunts for the COMMA idle symbol (0xBC) and declares lock after LOCK_COUNT consecutive aligned commas.
- Once locked, delivers one byte every 8 clocks with a valid qualifier. Valid is low for idle commas.

Parameters:
- WIDTH, 8, symbol width in bits (fixed at 8 for this PHY; kept parametric for the counters).
- COMMA, 8'hBC, idle/alignment symbol.
- LOCK_COUNT, 4, consecutive aligned commas needed to enter LOCKED; legal range 1..15.

Ports:
- clk  input  1  bit-rate clock (clk_32f domain of the PHY); all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial lane bit, MSB of each byte first.
- data_out  output  WIDTH  last aligned byte.
- valid_out  output  1  data_out is a payload byte (not COMMA).
- byte_stb  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  lane is aligned and locked.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values while reset==0:
  - sr=0, bit_cnt=0, comma_cnt=0, state=HUNT.
  - data_out=0, valid_out=0, byte_stb=0, active=0.
- Shift register: sr <= {sr[WIDTH-2:0], data_in} on every clock, in all states.
- HUNT (bit-level search):
  - sr is compared with COMMA at every clock.
  - On match: state->SYNC, comma_cnt<=1, bit_cnt<=0.
  - If LOCK_COUNT==1, go directly to LOCKED instead.
- Byte boundaries:
  - bit_cnt increments every clock after a HUNT match and wraps at WIDTH-1.
  - A boundary is the clock where bit_cnt==WIDTH-1. sr then holds exactly the WIDTH bits received since the previous comma or boundary.
  - The first boundary occurs exactly 8 clocks after the matching clock.
- SYNC, at each boundary:
  - If sr==COMMA: comma_cnt++. When comma_cnt reaches LOCK_COUNT, state->LOCKED.
  - If sr!=COMMA: state->HUNT, comma_cnt<=0.
  - No outputs change in SYNC; byte_stb stays 0.
- LOCKED, at each boundary (registered output, latency 1 clock from the boundary):
  - data_out<=sr.
  - valid_out<=(sr!=COMMA).
  - byte_stb<=1 for exactly one cycle.
  - data_out/valid_out are held between strobes.
- active:
  - Rises on the clock LOCKED is entered.
  - Stays high until reset; there is no loss-of-lock detection in the base block.
- Precedence: the lock-reaching comma produces no byte_stb. The first strobe is at the next boundary.
- Reset mid-operation: immediate return to all reset values. Alignment must be re-acquired from HUNT.
- Once in SYNC/LOCKED, bit_cnt never re-phases on a comma seen at a non-boundary offset.

Optional Feature:
- Macro: PHY_RX_LANE_RELOCK_EN.
- With the macro:
  - In LOCKED, a COMMA seen in sr at a non-boundary clock increments misalign_cnt (2 bits). A boundary comma clears it.
  - On the 3rd consecutive misaligned comma: state->HUNT, active<=0, valid_out<=0, comma_cnt<=0.
  - Extra output relock_evt (1 bit) pulses on that transition.
- Without the macro: no misalign_cnt, no relock_evt port, and LOCKED is terminal until reset.

Decomposition:
- Shared package phy_rx_pkg:
  - COMMA_SYM=8'hBC.
  - Default LOCK_COUNT.
  - State encoding localparams HUNT=2'd0, SYNC=2'd1, LOCKED=2'd2.
- One natural sub-module: phy_rx_bit_counter. It is a wrapping modulo-WIDTH counter with synchronous clear and a boundary flag, reusable by the transmit serializer.

Test Plan:
- Reset low for 5 clocks, then idle 0 bits -> all outputs 0, active=0, no byte_stb.
- 3 junk bits 101, then 4x 0xBC, then 0xA5 -> active rises at the 4th comma's boundary; one clock after the 0xA5 boundary, byte_stb=1, data_out=8'hA5, valid_out=1.
- 3x 0xBC, then 0x12 -> returns to HUNT, active stays 0; a further 4x 0xBC then 0x34 -> lock, data_out=8'h34 valid.
- Locked, then 0xBC, 0xFF, 0x00 -> strobes at 8-clock spacing: (BC,valid 0), (FF,valid 1), (00,valid 1).
- Locked, assert reset for 1 clock mid-byte -> outputs 0 immediately; 4x 0xBC + 0x5A needed to see data_out=8'h5A.
- With PHY_RX_LANE_RELOCK_EN: locked, stream shifted by 2 bits carrying 3x 0xBC -> relock_evt pulse, active=0; 4 more aligned commas -> active=1.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive lane front end.
//   COMMA_SYM          : idle / alignment symbol (K28.5-style 0xBC)
//   SYM_WIDTH          : lane symbol width in bits
//   DEFAULT_LOCK_COUNT : consecutive aligned commas required for lock
//   lane_state_t       : alignment state machine encoding
package phy_rx_pkg;

   localparam int unsigned SYM_WIDTH          = 8;
   localparam logic [7:0]  COMMA_SYM          = 8'hBC;
   localparam int unsigned DEFAULT_LOCK_COUNT = 4;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } lane_state_t;

endpackage

// File: rtl/phy_rx_lane_align_if.sv
// Lane-side signal bundle of phy_rx_lane_align.
//   data_in    : serial lane bit, MSB of each byte first
//   data_out   : last aligned byte
//   valid_out  : data_out is a payload byte (not the comma)
//   byte_stb   : one-cycle pulse when data_out/valid_out update
//   active     : lane aligned and locked
//   relock_evt : pulse on loss of alignment (only with PHY_RX_LANE_RELOCK_EN)
// Modports: master = upstream serial source / consumer side, slave = aligner.
interface phy_rx_lane_align_if #(
   parameter int unsigned WIDTH = 8
);
   logic             data_in;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             byte_stb;
   logic             active;
`ifdef PHY_RX_LANE_RELOCK_EN
   logic             relock_evt;

   modport master (output data_in,
                   input  data_out, valid_out, byte_stb, active, relock_evt);
   modport slave  (input  data_in,
                   output data_out, valid_out, byte_stb, active, relock_evt);
`else
   modport master (output data_in,
                   input  data_out, valid_out, byte_stb, active);
   modport slave  (input  data_in,
                   output data_out, valid_out, byte_stb, active);
`endif
endinterface

// File: rtl/phy_rx_bit_counter.sv
// Wrapping modulo-WIDTH bit counter with synchronous clear and a boundary
// flag. Shared by the receive aligner and the transmit serializer.
//   clk      : bit-rate clock, rising edge
//   reset    : asynchronous active-low reset
//   clear    : synchronous clear (count <= 0), overrides counting
//   boundary : high while count == WIDTH-1 (last bit of a symbol)
module phy_rx_bit_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic boundary
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign boundary = (count == LAST);

endmodule

// File: rtl/phy_rx_lane_align.sv
// Per-lane serial-to-parallel converter with comma-based byte alignment.
// Hunts bit-by-bit for COMMA, confirms LOCK_COUNT consecutive aligned commas,
// then delivers one byte per WIDTH clocks with a payload qualifier.
//   clk   : bit-rate clock, rising edge
//   reset : asynchronous active-low reset
//   lane  : phy_rx_lane_align_if.slave (data_in, data_out, valid_out,
//           byte_stb, active, and relock_evt when enabled)
// Optional feature macro: PHY_RX_LANE_RELOCK_EN -- three consecutive commas
// at a non-boundary offset while locked drop the lane back to HUNT.
module phy_rx_lane_align
   import phy_rx_pkg::*;
#(
   parameter int unsigned      WIDTH      = SYM_WIDTH,
   parameter logic [WIDTH-1:0] COMMA      = COMMA_SYM,
   parameter int unsigned      LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
   input  logic              clk,
   input  logic              reset,
   phy_rx_lane_align_if.slave lane
);

   localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_COUNT);

   lane_state_t      state;
   logic [WIDTH-1:0] sr;
   logic [3:0]       comma_cnt;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             stb_q;
   logic             active_q;
   logic             boundary;
   logic             sr_comma;
`ifdef PHY_RX_LANE_RELOCK_EN
   logic [1:0]       misalign_cnt;
   logic             relock_q;
`endif

   assign sr_comma = (sr == COMMA);

   // Held in clear during HUNT so the first boundary lands exactly WIDTH
   // clocks after the matching clock.
   phy_rx_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (state == HUNT),
      .boundary (boundary)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= HUNT;
         sr           <= '0;
         comma_cnt    <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         stb_q        <= 1'b0;
         active_q     <= 1'b0;
`ifdef PHY_RX_LANE_RELOCK_EN
         misalign_cnt <= '0;
         relock_q     <= 1'b0;
`endif
      end else begin
         sr    <= {sr[WIDTH-2:0], lane.data_in};
         stb_q <= 1'b0;
`ifdef PHY_RX_LANE_RELOCK_EN
         relock_q <= 1'b0;
`endif
         case (state)
            HUNT: begin
               if (sr_comma) begin
                  comma_cnt <= 4'd1;
                  if (LOCK_COUNT == 1) begin
                     state    <= LOCKED;
                     active_q <= 1'b1;
                  end else begin
                     state <= SYNC;
                  end
               end
            end
            SYNC: begin
               if (boundary) begin
                  if (sr_comma) begin
                     comma_cnt <= comma_cnt + 4'd1;
                     if ((comma_cnt + 4'd1) == LOCK_CNT_V) begin
                        state    <= LOCKED;
                        active_q <= 1'b1;
                     end
                  end else begin
                     state     <= HUNT;
                     comma_cnt <= '0;
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  data_q  <= sr;
                  valid_q <= !sr_comma;
                  stb_q   <= 1'b1;
`ifdef PHY_RX_LANE_RELOCK_EN
                  if (sr_comma) begin
                     misalign_cnt <= '0;
                  end
               end else if (sr_comma) begin
                  // Third consecutive off-phase comma: alignment is lost.
                  if (misalign_cnt == 2'd2) begin
                     state        <= HUNT;
                     active_q     <= 1'b0;
                     valid_q      <= 1'b0;
                     comma_cnt    <= '0;
                     misalign_cnt <= '0;
                     relock_q     <= 1'b1;
                  end else begin
                     misalign_cnt <= misalign_cnt + 2'd1;
                  end
`endif
               end
            end
            default: begin
               state <= HUNT;
            end
         endcase
      end
   end

   assign lane.data_out  = data_q;
   assign lane.valid_out = valid_q;
   assign lane.byte_stb  = stb_q;
   assign lane.active    = active_q;
`ifdef PHY_RX_LANE_RELOCK_EN
   assign lane.relock_evt = relock_q;
`endif

endmodule
